song_sequencer: RTL and testbench

Controller that sequences `note_player` through a song stored in a synchronous song ROM. It fetches {note, duration} entries one at a time, issues a one-cycle `load_new_note` to `note_player`, and waits for `done_with_note` before advancing. It sits between the top-level user controls (play/pause, song select) and `note_player`, with the song ROM as its only memory.

---
 rtl/music_pkg.sv | 11 +
 rtl/song_sequencer.sv | 93 +++++++++
 tb/tb_song_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// music_pkg: shared widths, sequencer state encoding and song-entry markers.
package music_pkg;
  localparam int NOTE_WIDTH = 6;
  localparam int DUR_WIDTH  = 6;
  localparam int SONG_BITS  = 2;
  localparam int INDEX_BITS = 5;
  localparam logic [NOTE_WIDTH-1:0] REST_NOTE    = '0;
  localparam logic [DUR_WIDTH-1:0]  END_DURATION = '0;
  localparam logic [INDEX_BITS-1:0] LAST_INDEX   = '1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, LOAD, PLAY, ADVANCE} state_e;
endpackage

// File: rtl/song_sequencer.sv
// song_sequencer: steps note_player through {note, duration} entries of an external 1-cycle song ROM.
module song_sequencer
  import music_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            play,
  input  logic [SONG_BITS-1:0]            song,
  input  logic                            new_song,
  output logic [SONG_BITS+INDEX_BITS-1:0] rom_addr,
  input  logic [NOTE_WIDTH+DUR_WIDTH-1:0] rom_data,
  output logic [NOTE_WIDTH-1:0]           note_to_load,
  output logic [DUR_WIDTH-1:0]            duration_to_load,
  output logic                            load_new_note,
  input  logic                            done_with_note,
  output logic                            play_enable,
  output logic                            song_done,
  output logic                            busy
);
  state_e                  state_q, state_d;
  logic [SONG_BITS-1:0]    song_q, song_d;
  logic [INDEX_BITS-1:0]   index_q, index_d;
  logic [NOTE_WIDTH-1:0]   note_q, note_d;
  logic [DUR_WIDTH-1:0]    dur_q, dur_d;
  logic                    load_q, load_d, done_q, done_d, busy_q;
  logic [DUR_WIDTH-1:0]    rom_dur;
  logic                    last;
  assign rom_dur          = rom_data[DUR_WIDTH-1:0];
  assign last             = index_q == LAST_INDEX;
  assign rom_addr         = {song_q, index_q};
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign load_new_note    = load_q;
  assign song_done        = done_q;
  assign busy             = busy_q;
  assign play_enable      = play;
  // Pulses are decided one state early so they appear registered in LOAD/ADVANCE.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    index_d = index_q;
    note_d  = note_q;
    dur_d   = dur_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
    if (new_song) begin
      state_d = FETCH;
      song_d  = song;
      index_d = '0;
    end else begin
      case (state_q)
        FETCH:    state_d = play ? WAIT_ROM : FETCH;
        WAIT_ROM: begin
          state_d         = LOAD;
          {note_d, dur_d} = rom_data;
          load_d          = rom_dur != END_DURATION;
          done_d          = rom_dur == END_DURATION;
        end
        LOAD:     state_d = (dur_q == END_DURATION) ? IDLE : PLAY;
        PLAY:     if (done_with_note) begin
          state_d = ADVANCE;
          done_d  = last;
        end
        ADVANCE:  begin
          state_d = last ? IDLE : FETCH;
          index_d = last ? index_q : index_q + 1'b1;
        end
        default:  ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      song_q  <= '0;
      index_q <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      index_q <= index_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      load_q  <= load_d;
      done_q  <= done_d;
      busy_q  <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scoreboard bench with a behavioural 1-cycle song ROM and a directed note_player.
module tb_song_sequencer;
  logic        clk = 1'b0;
  logic        reset_n, play, new_song, done_with_note;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_to_load, duration_to_load;
  logic        load_new_note, play_enable, song_done, busy;
  logic [11:0] mem [128];
  logic [11:0] exp_q [$];
  int          sd_q [$];
  logic [11:0] mon_e;
  int          mon_a;
  int          tests = 0, fails = 0, n;
  logic        seen1 = 1'b0, seen96 = 1'b0, in_full = 1'b0;

  song_sequencer dut (
    .clk(clk), .reset_n(reset_n), .play(play), .song(song), .new_song(new_song),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .load_new_note(load_new_note),
    .done_with_note(done_with_note), .play_enable(play_enable),
    .song_done(song_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (reset_n) begin
    if (load_new_note) begin
      if (exp_q.size() == 0) check("unexpected_load", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("load_note", int'(note_to_load), int'(mon_e[11:6]));
        check("load_dur", int'(duration_to_load), int'(mon_e[5:0]));
      end
    end
    if (song_done) begin
      if (sd_q.size() == 0) check("unexpected_song_done", 1, 0);
      else begin
        mon_a = sd_q.pop_front();
        check("song_done_addr", int'(rom_addr), mon_a);
      end
    end
    if (busy && rom_addr == 7'd1) seen1 = 1'b1;
    if (in_full && rom_addr == 7'd96) seen96 = 1'b1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic pulse_new(input logic [1:0] s);
    song = s; new_song = 1'b1; tick(); new_song = 1'b0;
  endtask
  task automatic do_done();
    done_with_note = 1'b1; tick(); done_with_note = 1'b0;
  endtask
  task automatic wait_load(output int c);
    c = 0;
    while (!load_new_note && c < 20) begin tick(); c++; end
  endtask
  task automatic wait_sd(output int c);
    c = 0;
    while (!song_done && c < 20) begin tick(); c++; end
  endtask
  task automatic check_zero(input string name);
    check({name, "_addr"}, int'(rom_addr), 0);
    check({name, "_note"}, int'(note_to_load), 0);
    check({name, "_dur"}, int'(duration_to_load), 0);
    check({name, "_load"}, int'(load_new_note), 0);
    check({name, "_sd"}, int'(song_done), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[0]  = {6'd5, 6'd1};
    mem[1]  = {6'd33, 6'd4};
    mem[32] = {6'd12, 6'd3};
    mem[33] = {6'd18, 6'd2};
    for (int i = 0; i < 32; i++) mem[64+i] = {6'(i + 1), 6'(i % 5 + 1)};
    mem[96] = {6'd0, 6'd5};
    mem[97] = {6'd40, 6'd0};
    reset_n = 1'b0; play = 1'b1; song = '0; new_song = 1'b0; done_with_note = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();
    // basic sequence, song 1
    exp_q.push_back({6'd12, 6'd3}); exp_q.push_back({6'd18, 6'd2}); sd_q.push_back(34);
    pulse_new(2'd1);
    check("basic_addr", int'(rom_addr), 32);
    check("basic_busy", int'(busy), 1);
    wait_load(n); check("basic_lat", n, 2);
    tick(); do_done();
    wait_load(n); check("basic_gap", n, 3);
    tick(); do_done();
    wait_sd(n); check("basic_end_lat", n, 3);
    check("basic_end_noload", int'(load_new_note), 0);
    tick(); check("basic_idle", int'(busy), 0);
    // stray done in IDLE
    do_done(); tick();
    check("stray_idle_busy", int'(busy), 0);
    // pause in FETCH and PLAY, stray done in FETCH
    exp_q.push_back({6'd12, 6'd3}); exp_q.push_back({6'd18, 6'd2}); sd_q.push_back(34);
    play = 1'b0;
    pulse_new(2'd1);
    repeat (4) tick();
    check("pause_fetch_load", int'(load_new_note), 0);
    check("pause_fetch_busy", int'(busy), 1);
    check("pause_enable_lo", int'(play_enable), 0);
    do_done(); tick();
    check("stray_fetch_addr", int'(rom_addr), 32);
    play = 1'b1; #1;
    check("pause_enable_hi", int'(play_enable), 1);
    wait_load(n); check("pause_resume_lat", n, 2);
    tick(); play = 1'b0;
    repeat (3) tick();
    check("pause_play_busy", int'(busy), 1);
    do_done(); repeat (4) tick();
    check("pause_adv_addr", int'(rom_addr), 33);
    check("pause_adv_load", int'(load_new_note), 0);
    play = 1'b1;
    wait_load(n); check("pause_resume2_lat", n, 2);
    tick(); do_done();
    wait_sd(n); check("pause_end_lat", n, 3);
    tick();
    // abort song 0 for song 2, then play song 2 through all 32 entries
    exp_q.push_back({6'd5, 6'd1});
    pulse_new(2'd0);
    wait_load(n); check("abort_first_lat", n, 2);
    tick();
    for (int i = 0; i < 32; i++) exp_q.push_back({6'(i + 1), 6'(i % 5 + 1)});
    sd_q.push_back(95);
    in_full = 1'b1;
    song = 2'd2; new_song = 1'b1; done_with_note = 1'b1;
    tick();
    new_song = 1'b0; done_with_note = 1'b0;
    check("abort_addr", int'(rom_addr), 64);
    check("abort_busy", int'(busy), 1);
    wait_load(n); check("abort_lat", n, 2);
    for (int i = 0; i < 32; i++) begin
      tick(); do_done();
      if (i < 31) begin
        wait_load(n); check("full_gap", n, 3);
      end
    end
    check("full_sd_adv", int'(song_done), 1);
    tick();
    check("full_idle", int'(busy), 0);
    check("full_addr_hold", int'(rom_addr), 95);
    in_full = 1'b0;
    // rest note then end marker carrying a nonzero note code
    exp_q.push_back({6'd0, 6'd5}); sd_q.push_back(97);
    pulse_new(2'd3);
    wait_load(n); check("rest_lat", n, 2);
    tick(); do_done();
    wait_sd(n); check("rest_end_lat", n, 3);
    check("marker_note", int'(note_to_load), 40);
    check("marker_dur", int'(duration_to_load), 0);
    tick();
    // asynchronous reset during PLAY
    exp_q.push_back({6'd12, 6'd3});
    pulse_new(2'd1);
    wait_load(n); check("rst_lat", n, 2);
    tick();
    check("rst_pre_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1 check_zero("async_rst");
    tick(); reset_n = 1'b1;
    do_done(); repeat (3) tick();
    check("rst_no_resume_busy", int'(busy), 0);
    check("rst_no_resume_addr", int'(rom_addr), 0);
    check("never_fetched_idx1", int'(seen1), 0);
    check("never_next_song", int'(seen96), 0);
    check("loads_left", exp_q.size(), 0);
    check("song_done_left", sd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
